// File: rtl/sample_pacer.sv
// sample_pacer: rate-matching buffer between the audio sample producer and the
// DAC-side consumer. Samples are accepted into a small FIFO and released at one
// per rising edge of sample_clock. Playback starts only once the FIFO is half
// full, and an empty FIFO at a tick sends the block back to priming.
//
// Handshake: a sample transfers on a rising clk edge when in_valid and in_ready
// are both 1. in_ready depends only on the registered fill count, so a pop in
// the same cycle never opens room for a push into a full FIFO. in_data is
// sampled only on a transfer edge.
module sample_pacer #(
    parameter int SAMPLE_WIDTH    = 16,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_clock,
    input  logic [SAMPLE_WIDTH-1:0]    in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [SAMPLE_WIDTH-1:0]    out_sample,
    output logic                       out_strobe,
    output logic [FIFO_DEPTH_LOG2:0]   fill,
    output logic                       running,
    output logic [7:0]                 underrun_count,
    input  logic                       clear_underrun
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0]   FILL_FULL = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};
    localparam logic [FIFO_DEPTH_LOG2:0]   FILL_HALF = FILL_FULL >> 1;
    localparam logic [FIFO_DEPTH_LOG2:0]   FILL_ONE  = {{FIFO_DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE   = {{(FIFO_DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic {
        PRIMING = 1'b0,
        RUNNING = 1'b1
    } state_t;

    state_t                        state;
    state_t                        state_next;
    logic                          sc_d;
    logic                          tick;
    logic                          push;
    logic                          pop;
    logic                          underrun;
    logic [FIFO_DEPTH_LOG2-1:0]    wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0]    rd_ptr;
    logic [SAMPLE_WIDTH-1:0]       mem [DEPTH];

    // sc_d resets high so a sample_clock already high out of reset is not a tick.
    assign tick     = sample_clock & ~sc_d;
    assign in_ready = (fill != FILL_FULL);
    assign push     = in_valid & in_ready;
    assign running  = (state == RUNNING);

    // Edge-detect register for sample_clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sc_d <= 1'b1;
        end else begin
            sc_d <= sample_clock;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= PRIMING;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus pop/underrun decode; a tick in PRIMING only strobes.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        underrun   = 1'b0;
        case (state)
            PRIMING: begin
                if (fill >= FILL_HALF) begin
                    state_next = RUNNING;
                end
            end
            RUNNING: begin
                if (tick) begin
                    if (fill != '0) begin
                        pop = 1'b1;
                    end else begin
                        underrun   = 1'b1;
                        state_next = PRIMING;
                    end
                end
            end
            default: state_next = PRIMING;
        endcase
    end

    // FIFO storage; contents are invalidated by the pointer/fill reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves fill unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   fill <= fill + FILL_ONE;
                2'b01:   fill <= fill - FILL_ONE;
                default: fill <= fill;
            endcase
        end
    end

    // Output register: strobe on every tick, new sample only on a pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_strobe <= 1'b0;
            out_sample <= '0;
        end else begin
            out_strobe <= tick;
            if (pop) begin
                out_sample <= mem[rd_ptr];
            end
        end
    end

    // Saturating underrun counter; a clear overrides a same-cycle underrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underrun_count <= 8'd0;
        end else if (clear_underrun) begin
            underrun_count <= 8'd0;
        end else if (underrun && (underrun_count != 8'hFF)) begin
            underrun_count <= underrun_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_sample_pacer.sv
// Bench for sample_pacer: a queue-based model of the pacer is compared with the
// DUT on every falling clk edge, and directed sequences add literal checks.
module tb_sample_pacer;

    localparam int W = 16;
    localparam int L = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             sample_clock = 1'b1;
    logic [W-1:0]     in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     out_sample;
    logic             out_strobe;
    logic [L:0]       fill;
    logic             running;
    logic [7:0]       underrun_count;
    logic             clear_underrun = 1'b0;

    int checks = 0;
    int errors = 0;

    sample_pacer #(.SAMPLE_WIDTH(W), .FIFO_DEPTH_LOG2(L)) dut (
        .clk            (clk),
        .rst            (rst),
        .sample_clock   (sample_clock),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_sample     (out_sample),
        .out_strobe     (out_strobe),
        .fill           (fill),
        .running        (running),
        .underrun_count (underrun_count),
        .clear_underrun (clear_underrun)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_q[$];
    bit           m_running = 1'b0;
    bit           m_sc_prev = 1'b1;
    logic [W-1:0] m_sample  = '0;
    bit           m_strobe  = 1'b0;
    int           m_under   = 0;

    // Model: one step per clk edge, using the occupancy seen before this edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q.delete();
            m_running = 1'b0;
            m_sc_prev = 1'b1;
            m_sample  = '0;
            m_strobe  = 1'b0;
            m_under   = 0;
        end else begin
            bit m_tick;
            bit m_accept;
            bit m_empty_tick;
            int old_size;
            old_size     = m_q.size();
            m_tick       = sample_clock && !m_sc_prev;
            m_sc_prev    = sample_clock;
            m_accept     = in_valid && (old_size != 16);
            m_strobe     = m_tick;
            m_empty_tick = 1'b0;
            if (m_tick && m_running) begin
                if (old_size != 0) m_sample = m_q.pop_front();
                else m_empty_tick = 1'b1;
            end
            if (m_accept) m_q.push_back(in_data);
            if (clear_underrun) m_under = 0;
            else if (m_empty_tick && m_under < 255) m_under = m_under + 1;
            if (!m_running) m_running = (old_size >= 8);
            else if (m_empty_tick) m_running = 1'b0;
        end
    end

    // Compare every output with the model on each falling edge.
    always @(negedge clk) begin
        check("out_sample", 32'(out_sample), 32'(m_sample));
        check("out_strobe", 32'(out_strobe), 32'(m_strobe));
        check("fill", 32'(fill), 32'(m_q.size()));
        check("in_ready", 32'(in_ready), 32'(m_q.size() != 16));
        check("running", 32'(running), 32'(m_running));
        check("underrun_count", 32'(underrun_count), 32'(m_under));
    end

    // ---------------- driver tasks ----------------
    task automatic do_tick(output logic st, output logic [W-1:0] s);
        @(negedge clk);
        sample_clock = 1'b1;
        @(negedge clk);
        st = out_strobe;
        s  = out_sample;
        sample_clock = 1'b0;
    endtask

    task automatic push_one(input logic [W-1:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Prime with 8 samples, drain them, then force one underrun.
    task automatic prime_and_underrun(input logic [W-1:0] base);
        logic st;
        logic [W-1:0] s;
        for (int i = 0; i < 8; i++) push_one(base + W'(i));
        idle_in();
        @(negedge clk);
        for (int i = 0; i < 9; i++) do_tick(st, s);
    endtask

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        logic st;
        logic [W-1:0] s;
        logic [W-1:0] exp_tab [10];

        rst = 1'b1;
        #1 rst = 1'b0;
        #22;
        check("rst out_sample", 32'(out_sample), 32'h0);
        check("rst out_strobe", 32'(out_strobe), 32'h0);
        check("rst fill", 32'(fill), 32'h0);
        check("rst in_ready", 32'(in_ready), 32'h1);
        check("rst running", 32'(running), 32'h0);
        check("rst underrun_count", 32'(underrun_count), 32'h0);

        // Release with sample_clock high: no strobe until a 0->1 transition.
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no false tick", 32'(out_strobe), 32'h0);
        end
        sample_clock = 1'b0;
        do_tick(st, s);
        check("priming tick strobe", 32'(st), 32'h1);
        check("priming tick sample", 32'(s), 32'h0);
        @(negedge clk);
        check("strobe one cycle", 32'(out_strobe), 32'h0);

        // Prime with 1..8, running rises one cycle after fill reaches 8.
        for (int i = 1; i <= 8; i++) push_one(W'(i));
        idle_in();
        check("primed fill", 32'(fill), 32'd8);
        check("running not yet", 32'(running), 32'h0);
        @(negedge clk);
        check("running after prime", 32'(running), 32'h1);
        for (int i = 1; i <= 8; i++) begin
            do_tick(st, s);
            check("play strobe", 32'(st), 32'h1);
            check("play sample", 32'(s), 32'(i));
        end
        do_tick(st, s);
        check("underrun strobe", 32'(st), 32'h1);
        check("underrun holds sample", 32'(s), 32'h8);
        check("underrun count 1", 32'(underrun_count), 32'h1);
        check("underrun leaves running", 32'(running), 32'h0);

        // Continuous valid with no ticks fills to 16 and stalls.
        for (int k = 0; k < 20; k++) push_one(16'h0100 + W'(k));
        push_one(16'h0200);
        check("full fill", 32'(fill), 32'd16);
        check("full in_ready", 32'(in_ready), 32'h0);
        do_tick(st, s);
        check("pop from full", 32'(s), 32'h0100);
        check("fill after pop", 32'(fill), 32'd15);
        check("ready after pop", 32'(in_ready), 32'h1);
        idle_in();
        check("17th accepted", 32'(fill), 32'd16);
        for (int i = 0; i < 16; i++) begin
            do_tick(st, s);
            check("drain sample", 32'(s), (i < 15) ? 32'(16'h0101 + i) : 32'h0200);
        end

        // Push coincident with a tick at fill 5, then wrap the pointers.
        for (int i = 0; i < 5; i++) push_one(16'h0300 + W'(i));
        @(negedge clk);
        in_valid     = 1'b1;
        in_data      = 16'h03AA;
        sample_clock = 1'b1;
        @(negedge clk);
        in_valid     = 1'b0;
        sample_clock = 1'b0;
        check("push+pop fill", 32'(fill), 32'd5);
        check("push+pop sample", 32'(out_sample), 32'h0300);
        check("push+pop strobe", 32'(out_strobe), 32'h1);
        for (int i = 0; i < 5; i++) push_one(16'h0310 + W'(i));
        idle_in();
        exp_tab = '{16'h0301, 16'h0302, 16'h0303, 16'h0304, 16'h03AA,
                    16'h0310, 16'h0311, 16'h0312, 16'h0313, 16'h0314};
        for (int i = 0; i < 10; i++) begin
            do_tick(st, s);
            check("wrap sample", 32'(s), 32'(exp_tab[i]));
        end
        do_tick(st, s);
        check("underrun count 2", 32'(underrun_count), 32'h2);

        // Plain clear, then saturation over 300 underruns.
        @(negedge clk);
        clear_underrun = 1'b1;
        @(negedge clk);
        clear_underrun = 1'b0;
        check("clear alone", 32'(underrun_count), 32'h0);
        for (int n = 0; n < 300; n++) prime_and_underrun(W'(n * 8));
        check("saturated", 32'(underrun_count), 32'd255);

        // Clear coincident with an underrun wins.
        for (int i = 0; i < 8; i++) push_one(16'h0500 + W'(i));
        idle_in();
        @(negedge clk);
        for (int i = 0; i < 8; i++) do_tick(st, s);
        check("last before clear", 32'(s), 32'h0507);
        @(negedge clk);
        sample_clock   = 1'b1;
        clear_underrun = 1'b1;
        @(negedge clk);
        sample_clock   = 1'b0;
        clear_underrun = 1'b0;
        check("clear beats underrun", 32'(underrun_count), 32'h0);
        check("underrun drops running", 32'(running), 32'h0);

        // Asynchronous reset mid-operation discards contents at once.
        for (int i = 0; i < 3; i++) push_one(16'h0600 + W'(i));
        idle_in();
        #2 rst = 1'b0;
        #1;
        check("async rst fill", 32'(fill), 32'h0);
        check("async rst ready", 32'(in_ready), 32'h1);
        check("async rst sample", 32'(out_sample), 32'h0);
        check("async rst running", 32'(running), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sample_pacer.md
# sample_pacer

Rate-matching buffer between the audio sample producer and the DAC-side consumer. It accepts samples from the producer over a valid/ready handshake into a small FIFO. It releases exactly one sample per rising edge of the `sample_clock` square wave from the sample-clock divider. It primes the FIFO before playback and recovers from underruns by re-priming.

## Interface
Parameters:
- `SAMPLE_WIDTH`, 16: bits per sample.
- `FIFO_DEPTH_LOG2`, 4: FIFO depth is 2^FIFO_DEPTH_LOG2 entries (16).

Ports:
- `clk`  in  1  system clock; sole clock of the block.
- `rst`  in  1  reset, asynchronous, active-low.
- `sample_clock`  in  1  square wave from the sample-clock divider, synchronous to `clk`.
- `in_data`  in  SAMPLE_WIDTH  producer sample.
- `in_valid`  in  1  producer has a sample.
- `in_ready`  out  1  FIFO can accept; a transfer occurs when `in_valid` and `in_ready` are both 1.
- `out_sample`  out  SAMPLE_WIDTH  current sample to DAC, registered.
- `out_strobe`  out  1  one-cycle pulse per sample period, registered.
- `fill`  out  FIFO_DEPTH_LOG2+1  FIFO occupancy, 0..DEPTH.
- `running`  out  1  1 in state RUNNING.
- `underrun_count`  out  8  saturating underrun counter.
- `clear_underrun`  in  1  synchronous clear of `underrun_count`.

## Operation
- Tick detect: `sc_d` is a register of `sample_clock`, with reset value 1 so that a high `sample_clock` out of reset does not produce a false tick. `tick` = `sample_clock` & ~`sc_d`.
- FIFO:
  - Write pointer, read pointer and `fill` are registered; both pointers wrap modulo DEPTH.
  - `in_ready` = (`fill` != DEPTH), decoded from the registered count only.
  - When full, a same-cycle pop does not enable a push.
  - A push and a pop in the same cycle leave `fill` unchanged.
- There is no bypass: a sample pushed in cycle N is not poppable before cycle N+1.
- State machine, two states, reset to PRIMING:
  - PRIMING:
    - On `tick`: pulse `out_strobe`, hold `out_sample`, no pop, no underrun count.
    - Go to RUNNING at the clock edge where `fill` >= DEPTH/2, evaluated on the registered `fill`.
  - RUNNING, on `tick` with `fill` != 0: pop the head into `out_sample` and pulse `out_strobe`.
  - RUNNING, on `tick` with `fill` == 0:
    - Pulse `out_strobe` and hold `out_sample`.
    - Increment `underrun_count`, saturating at 255.
    - Return to PRIMING.
- Ticks never stall: `out_strobe` pulses exactly once per `sample_clock` rising edge in every state.
- `clear_underrun` sets `underrun_count` to 0 at the next edge. If it coincides with an underrun, the clear wins and the count is 0.
- `running` = (state == RUNNING).

## Timing
- Reset values: `out_sample` 0, `out_strobe` 0, `fill` 0, `in_ready` 1, `running` 0, `underrun_count` 0, pointers 0, `sc_d` 1.
- Reset asserted mid-operation discards FIFO contents immediately (asynchronous) and returns the block to PRIMING.
- Tick latency: if `sample_clock` first reads 1 in cycle N, then `out_strobe` and `out_sample` are visible in cycle N+1. `out_strobe` lasts one cycle.
- Push latency: a handshake in cycle N is reflected in `fill` in cycle N+1.
- PRIMING→RUNNING: if `fill` reaches DEPTH/2 in cycle N, `running` = 1 in cycle N+1. A tick in cycle N is still treated as PRIMING.
- Throughput: one push per cycle when not full. At most one pop per `sample_clock` period, which is at least 2 `clk` cycles.

## Test plan
- Reset with `sample_clock` held high, then release -> no `out_strobe` until `sample_clock` goes 0 then 1. All outputs equal their reset values.
- Push 0x0001..0x0008 with `sample_clock` idle -> `running` rises 1 cycle after `fill` = 8. The next 8 ticks output 0x0001..0x0008 in order, one `out_strobe` each.
- Hold `in_valid` = 1 continuously, no ticks -> `fill` stops at 16 and `in_ready` = 0. A tick pops one entry; `in_ready` returns to 1 the following cycle and the 17th sample enters.
- Prime with 8 samples, then stop pushing -> the 9th tick pulses `out_strobe` with `out_sample` held at sample 8. `underrun_count` = 1 and `running` = 0.
- Push in the same cycle as a tick with `fill` = 5 in RUNNING -> `fill` stays 5 and pointers wrap correctly across index 15→0.
- Force 300 underruns -> `underrun_count` saturates at 255. `clear_underrun` coincident with an underrun -> count reads 0.
